// File: rtl/hyperram_pkg.sv
// rtl/hyperram_pkg.sv - shared types, CA bit positions and CA encoder for the HyperRAM command sequencer
package hyperram_pkg;

   typedef enum logic [1:0] {
      OP_RDMEM   = 2'd0,
      OP_WRMEM   = 2'd1,
      OP_RDREG   = 2'd2,
      OP_ILLEGAL = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LAUNCH   = 3'd1,
      ST_WAIT_END = 3'd2,
      ST_RESP     = 3'd3,
      ST_GAP      = 3'd4
   } state_e;

   localparam int CA_RW_BIT    = 47;
   localparam int CA_AS_BIT    = 46;
   localparam int CA_BURST_BIT = 45;
   localparam int CA_ROW_HI    = 44;
   localparam int CA_ROW_LO    = 16;
   localparam int CA_COL_HI    = 2;
   localparam int CA_COL_LO    = 0;

   // Reads (memory or register) set R/W#; only register reads set the address-space bit.
   function automatic logic [47:0] ca_encode(op_e op, logic [31:0] addr);
      logic [47:0] ca;
      ca                        = '0;
      ca[CA_RW_BIT]             = (op == OP_RDMEM) || (op == OP_RDREG);
      ca[CA_AS_BIT]             = (op == OP_RDREG);
      ca[CA_BURST_BIT]          = 1'b1;
      ca[CA_ROW_HI:CA_ROW_LO]   = addr[31:3];
      ca[CA_COL_HI:CA_COL_LO]   = addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hyperram_cmd_seq_if.sv
// rtl/hyperram_cmd_seq_if.sv - user request/response bus of the HyperRAM command sequencer
interface hyperram_cmd_seq_if;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [31:0]  req_addr;
   logic [255:0] req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [255:0] rsp_rdata;
   logic         rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/hyperram_line_collector.sv
// rtl/hyperram_line_collector.sv - read-data line shift register with word count and register load
module hyperram_line_collector
   import hyperram_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         shift,
   input  logic [31:0]  word,
   input  logic         load,
   input  logic [15:0]  reg_data,
   output logic [255:0] line,
   output logic [3:0]   count
);

   // Clear wins; a register load overrides a same-cycle word shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line  <= '0;
         count <= '0;
      end else if (clear) begin
         line  <= '0;
         count <= '0;
      end else begin
         if (shift) begin
            line  <= {line[223:0], word};
            count <= count + 4'd1;
         end
         if (load) begin
            line <= {240'h0, reg_data};
         end
      end
   end

endmodule

// File: rtl/hyperram_cmd_seq.sv
// rtl/hyperram_cmd_seq.sv - HyperRAM command sequencer: accept, CA encode, launch, collect, respond
module hyperram_cmd_seq
   import hyperram_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CSHI_CYCLES    = 2
) (
   input  logic                clk,
   input  logic                rst,
   hyperram_cmd_seq_if.slave   user,
   output logic [47:0]         casig,
   output logic [255:0]        databuffer,
   output logic [1:0]          sel,
   output logic                rdmem_start,
   output logic                wrmem_start,
   output logic                rdreg_start,
   input  logic                rdmem_end,
   input  logic                wrmem_end,
   input  logic                rdreg_end,
   input  logic                rdmem_wordvalid,
   input  logic [31:0]         rdmem_data,
   input  logic                rdreg_valid,
   input  logic [15:0]         rdreg_data,
   output logic                busy
);

   state_e       state_q, state_d;
   op_e          op_q;
   logic [15:0]  wdog_q, wdog_d;
   logic [15:0]  gap_q, gap_d;
   logic         req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
   logic         err_d;
   logic         coll_clear;
   logic         accept;
   logic         sel_end;
   logic         timeout;
   logic         in_wait;
   logic [3:0]   coll_count;
   logic [3:0]   cnt_fin;
   logic [255:0] coll_line;
   op_e          req_op_e;

   assign req_op_e = op_e'(user.req_op);
   assign accept   = (state_q == ST_IDLE) && user.req_valid && req_ready_q;
   assign in_wait  = (state_q == ST_WAIT_END);
   assign timeout  = (wdog_q + 16'd1) == 16'(TIMEOUT_CYCLES);
   assign cnt_fin  = coll_count + {3'b000, rdmem_wordvalid};

   // Only the end strobe of the op in flight can terminate the wait.
   always_comb begin
      sel_end = 1'b0;
      case (op_q)
         OP_RDMEM: sel_end = rdmem_end;
         OP_WRMEM: sel_end = wrmem_end;
         OP_RDREG: sel_end = rdreg_end;
         default:  sel_end = 1'b0;
      endcase
   end

   // Next-state logic plus watchdog, gap counter, error and collector-clear control.
   always_comb begin
      state_d    = state_q;
      wdog_d     = wdog_q;
      gap_d      = gap_q;
      err_d      = rsp_err_q;
      coll_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_op_e == OP_ILLEGAL) begin
                  state_d    = ST_RESP;
                  err_d      = 1'b1;
                  coll_clear = 1'b1;
               end else begin
                  state_d = ST_LAUNCH;
                  err_d   = 1'b0;
               end
            end
         end
         ST_LAUNCH: begin
            coll_clear = 1'b1;
            wdog_d     = '0;
            state_d    = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            wdog_d = wdog_q + 16'd1;
            if (sel_end) begin
               state_d = ST_RESP;
               err_d   = (op_q == OP_RDMEM) && (cnt_fin != 4'd8);
            end else if (timeout) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (user.rsp_ready) begin
               gap_d   = '0;
               state_d = (CSHI_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == 16'(CSHI_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with its counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         wdog_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         gap_q   <= gap_d;
      end
   end

   // Registered outputs: status flags follow the next state, command fields load on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         rdmem_start <= 1'b0;
         wrmem_start <= 1'b0;
         rdreg_start <= 1'b0;
         casig       <= '0;
         databuffer  <= '0;
         sel         <= '0;
         op_q        <= OP_RDMEM;
      end else begin
         req_ready_q <= (state_d == ST_IDLE);
         rsp_valid_q <= (state_d == ST_RESP);
         rsp_err_q   <= err_d;
         busy_q      <= (state_d != ST_IDLE);
         rdmem_start <= accept && (req_op_e == OP_RDMEM);
         wrmem_start <= accept && (req_op_e == OP_WRMEM);
         rdreg_start <= accept && (req_op_e == OP_RDREG);
         if (accept) begin
            casig      <= ca_encode(req_op_e, user.req_addr);
            databuffer <= user.req_wdata;
            sel        <= user.req_op;
            op_q       <= req_op_e;
         end
      end
   end

   hyperram_line_collector u_collector (
      .clk      (clk),
      .rst      (rst),
      .clear    (coll_clear),
      .shift    (in_wait && rdmem_wordvalid),
      .word     (rdmem_data),
      .load     (in_wait && rdreg_valid),
      .reg_data (rdreg_data),
      .line     (coll_line),
      .count    (coll_count)
   );

   assign user.req_ready = req_ready_q;
   assign user.rsp_valid = rsp_valid_q;
   assign user.rsp_err   = rsp_err_q;
   assign user.rsp_rdata = coll_line;
   assign busy           = busy_q;

endmodule

// File: tb/tb_hyperram_cmd_seq.sv
// tb/tb_hyperram_cmd_seq.sv - self-checking bench for hyperram_cmd_seq
module tb_hyperram_cmd_seq;

   localparam int TMO  = 20;
   localparam int CSHI = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [47:0]  casig;
   logic [255:0] databuffer;
   logic [1:0]   sel;
   logic         rdmem_start, wrmem_start, rdreg_start;
   logic         rdmem_end, wrmem_end, rdreg_end;
   logic         rdmem_wordvalid;
   logic [31:0]  rdmem_data;
   logic         rdreg_valid;
   logic [15:0]  rdreg_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   hyperram_cmd_seq_if u_if ();

   always #5 clk = ~clk;

   hyperram_cmd_seq #(.TIMEOUT_CYCLES(TMO), .CSHI_CYCLES(CSHI)) dut (
      .clk             (clk),
      .rst             (rst),
      .user            (u_if),
      .casig           (casig),
      .databuffer      (databuffer),
      .sel             (sel),
      .rdmem_start     (rdmem_start),
      .wrmem_start     (wrmem_start),
      .rdreg_start     (rdreg_start),
      .rdmem_end       (rdmem_end),
      .wrmem_end       (wrmem_end),
      .rdreg_end       (rdreg_end),
      .rdmem_wordvalid (rdmem_wordvalid),
      .rdmem_data      (rdmem_data),
      .rdreg_valid     (rdreg_valid),
      .rdreg_data      (rdreg_data),
      .busy            (busy)
   );

   // Reference CA word from arithmetic on the address fields.
   function automatic logic [47:0] model_ca(int op, logic [31:0] addr);
      logic [47:0] r;
      r = 48'(addr >> 3) * 48'h10000 + 48'(addr % 8) + 48'h2000_0000_0000;
      if (op != 1) r = r + 48'h8000_0000_0000;
      if (op == 2) r = r + 48'h4000_0000_0000;
      return r;
   endfunction

   // Reference line: most recent word in the lowest slot, up to eight words kept.
   function automatic logic [255:0] model_line(logic [31:0] q[$]);
      logic [255:0] r;
      int n;
      r = '0;
      n = q.size();
      for (int j = 0; j < 8 && j < n; j++) r[32*j +: 32] = q[n-1-j];
      return r;
   endfunction

   task automatic idle_inputs();
      u_if.req_valid  = 1'b0;
      u_if.req_op     = 2'd0;
      u_if.req_addr   = '0;
      u_if.req_wdata  = '0;
      u_if.rsp_ready  = 1'b0;
      rdmem_end       = 1'b0;
      wrmem_end       = 1'b0;
      rdreg_end       = 1'b0;
      rdmem_wordvalid = 1'b0;
      rdmem_data      = '0;
      rdreg_valid     = 1'b0;
      rdreg_data      = '0;
   endtask

   task automatic check_all_reset(input string tag);
      checks++;
      if ({u_if.req_ready, u_if.rsp_valid, u_if.rsp_err, busy, rdmem_start, wrmem_start, rdreg_start} !== 7'b0 ||
          casig !== 48'h0 || databuffer !== 256'h0 || sel !== 2'b0 || u_if.rsp_rdata !== 256'h0) begin
         errors++;
         $display("FAIL %s reset_outputs: got ready=%b valid=%b err=%b busy=%b starts=%b%b%b casig=%h sel=%b want all zero",
                  tag, u_if.req_ready, u_if.rsp_valid, u_if.rsp_err, busy, rdmem_start, wrmem_start, rdreg_start, casig, sel);
      end
   endtask

   task automatic wait_ready(input string tag);
      int guard;
      guard = 0;
      while (u_if.req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (u_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready_timeout: got %b want 1", tag, u_if.req_ready);
      end
   endtask

   // One complete transaction with the downstream FSM emulated by the bench.
   task automatic run_txn(input int op, input logic [31:0] addr, input logic [47:0] exp_casig,
                          input logic [255:0] wdata, input int nwords, input bit fixed_words,
                          input bit last_with_end, input bit stray, input int ready_delay,
                          input logic [15:0] regval, input string tag);
      logic [31:0]  words[$];
      logic [255:0] exp_line;
      logic         exp_err;
      logic [2:0]   exp_st;
      int           nfeed;
      words = {};
      wait_ready(tag);
      u_if.req_valid = 1'b1;
      u_if.req_op    = 2'(op);
      u_if.req_addr  = addr;
      u_if.req_wdata = wdata;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      if (op == 3) begin
         exp_line = '0;
         exp_err  = 1'b1;
         checks++;
         if ({rdmem_start, wrmem_start, rdreg_start} !== 3'b000) begin
            errors++;
            $display("FAIL %s illegal_start: got %b want 000", tag, {rdmem_start, wrmem_start, rdreg_start});
         end
      end else begin
         exp_st = (op == 0) ? 3'b100 : (op == 1) ? 3'b010 : 3'b001;
         checks++;
         if ({rdmem_start, wrmem_start, rdreg_start} !== exp_st || casig !== exp_casig ||
             sel !== 2'(op) || databuffer !== wdata || busy !== 1'b1 || u_if.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s launch: got starts=%b casig=%h sel=%0d busy=%b ready=%b want starts=%b casig=%h sel=%0d busy=1 ready=0 dbuf_ok=%b",
                     tag, {rdmem_start, wrmem_start, rdreg_start}, casig, sel, busy, u_if.req_ready,
                     exp_st, exp_casig, op, databuffer === wdata);
         end
         @(negedge clk);
         checks++;
         if ({rdmem_start, wrmem_start, rdreg_start} !== 3'b000) begin
            errors++;
            $display("FAIL %s start_width: got %b want 000", tag, {rdmem_start, wrmem_start, rdreg_start});
         end
         if (stray) begin
            wrmem_end = (op != 1);
            rdmem_end = (op != 0);
            rdreg_end = (op != 2);
            @(negedge clk);
            {rdmem_end, wrmem_end, rdreg_end} = 3'b000;
            checks++;
            if (u_if.rsp_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s stray_end: got rsp_valid=%b want 0", tag, u_if.rsp_valid);
            end
         end
         exp_line = '0;
         exp_err  = 1'b0;
         if (op == 0) begin
            nfeed = (last_with_end && nwords > 0) ? nwords - 1 : nwords;
            for (int i = 0; i < nfeed; i++) begin
               if (!fixed_words && $urandom_range(0, 2) == 0) @(negedge clk);
               rdmem_wordvalid = 1'b1;
               rdmem_data      = fixed_words ? 32'(i + 1) * 32'h1111_1111 : $urandom;
               words.push_back(rdmem_data);
               @(negedge clk);
               rdmem_wordvalid = 1'b0;
            end
            if (last_with_end && nwords > 0) begin
               rdmem_wordvalid = 1'b1;
               rdmem_data      = $urandom;
               words.push_back(rdmem_data);
            end
            exp_line = model_line(words);
            exp_err  = ((words.size() % 16) != 8);
         end else if (op == 2) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rdreg_valid = 1'b1;
            rdreg_data  = regval;
            @(negedge clk);
            rdreg_valid = 1'b0;
            exp_line    = {240'h0, regval};
         end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         u_if.rsp_ready = (ready_delay == 0);
         case (op)
            0:       rdmem_end = 1'b1;
            1:       wrmem_end = 1'b1;
            default: rdreg_end = 1'b1;
         endcase
         @(negedge clk);
         {rdmem_end, wrmem_end, rdreg_end} = 3'b000;
         rdmem_wordvalid = 1'b0;
      end
      checks++;
      if (u_if.rsp_valid !== 1'b1 || u_if.rsp_rdata !== exp_line || u_if.rsp_err !== exp_err || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s response: got valid=%b err=%b busy=%b rdata=%h want valid=1 err=%b busy=1 rdata=%h",
                  tag, u_if.rsp_valid, u_if.rsp_err, busy, u_if.rsp_rdata, exp_err, exp_line);
      end
      if (u_if.rsp_ready !== 1'b1) begin
         for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            checks++;
            if (u_if.rsp_valid !== 1'b1 || u_if.rsp_rdata !== exp_line || u_if.rsp_err !== exp_err) begin
               errors++;
               $display("FAIL %s hold_cycle%0d: got valid=%b err=%b rdata=%h want valid=1 err=%b rdata=%h",
                        tag, d, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata, exp_err, exp_line);
            end
         end
         u_if.rsp_ready = 1'b1;
      end
      @(negedge clk);
      u_if.rsp_ready = 1'b0;
      for (int g = 0; g < CSHI; g++) begin
         checks++;
         if (u_if.rsp_valid !== 1'b0 || u_if.req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s gap%0d: got valid=%b ready=%b busy=%b want 0 0 1", tag, g, u_if.rsp_valid, u_if.req_ready, busy);
         end
         @(negedge clk);
      end
      checks++;
      if (u_if.req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s reaccept: got ready=%b busy=%b want 1 0", tag, u_if.req_ready, busy);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_reset("reset");
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (u_if.req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset release_ready: got ready=%b busy=%b want 1 0", u_if.req_ready, busy);
      end
   endtask

   task automatic test_rdmem();
      run_txn(0, 32'h0000_0123, 48'hA000_0024_0003, {8{32'hCAFE_F00D}}, 8, 1'b1, 1'b0, 1'b0, 1, 16'h0, "rdmem");
   endtask

   task automatic test_wrmem();
      logic [255:0] pat;
      for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      run_txn(1, 32'h0000_0010, 48'h2000_0002_0000, pat, 0, 1'b0, 1'b0, 1'b0, 1, 16'h0, "wrmem");
   endtask

   task automatic test_rdreg();
      run_txn(2, 32'h0000_1000, 48'hE000_0200_0000, '0, 0, 1'b0, 1'b0, 1'b0, 2, 16'h8F1F, "rdreg");
   endtask

   task automatic test_short_burst();
      run_txn(0, 32'h0000_0040, model_ca(0, 32'h40), '0, 6, 1'b0, 1'b0, 1'b0, 1, 16'h0, "short6");
      run_txn(0, 32'h0000_0048, model_ca(0, 32'h48), '0, 8, 1'b0, 1'b1, 1'b0, 1, 16'h0, "last_with_end");
   endtask

   task automatic test_timeout();
      logic [31:0] words[$];
      int cyc;
      words = {};
      wait_ready("timeout");
      u_if.req_valid = 1'b1;
      u_if.req_op    = 2'd0;
      u_if.req_addr  = 32'h0000_0200;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      @(negedge clk);
      cyc = 1;
      for (int i = 0; i < 3; i++) begin
         rdmem_wordvalid = 1'b1;
         rdmem_data      = $urandom;
         words.push_back(rdmem_data);
         @(negedge clk);
         cyc++;
      end
      rdmem_wordvalid = 1'b0;
      while (u_if.rsp_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != TMO + 1 || u_if.rsp_err !== 1'b1 || u_if.rsp_rdata !== model_line(words)) begin
         errors++;
         $display("FAIL timeout response: got cycles=%0d err=%b rdata=%h want cycles=%0d err=1 rdata=%h",
                  cyc, u_if.rsp_err, u_if.rsp_rdata, TMO + 1, model_line(words));
      end
      u_if.rsp_ready = 1'b1;
      @(negedge clk);
      u_if.rsp_ready = 1'b0;
      checks++;
      if (u_if.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout handshake: got rsp_valid=%b want 0", u_if.rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      run_txn(1, 32'h0000_0300, model_ca(1, 32'h300), {8{32'h0F0F_1234}}, 0, 1'b0, 1'b0, 1'b0, 5, 16'h0, "backpressure");
   endtask

   task automatic test_illegal();
      run_txn(3, 32'h0000_0008, 48'h0, '0, 0, 1'b0, 1'b0, 1'b0, 2, 16'h0, "illegal");
   endtask

   task automatic test_stray_end();
      run_txn(0, 32'h0000_0500, model_ca(0, 32'h500), '0, 8, 1'b0, 1'b0, 1'b1, 1, 16'h0, "stray_rdmem");
      run_txn(2, 32'h0000_0504, model_ca(2, 32'h504), '0, 0, 1'b0, 1'b0, 1'b1, 1, 16'h1234, "stray_rdreg");
   endtask

   task automatic test_back_to_back();
      run_txn(1, 32'h0000_0600, model_ca(1, 32'h600), {8{32'h5555_AAAA}}, 0, 1'b0, 1'b0, 1'b0, 0, 16'h0, "b2b_0");
      run_txn(0, 32'h0000_0608, model_ca(0, 32'h608), '0, 8, 1'b0, 1'b0, 1'b0, 0, 16'h0, "b2b_1");
   endtask

   task automatic test_random();
      int op, nw;
      logic [31:0] addr;
      logic [255:0] wd;
      for (int t = 0; t < 25; t++) begin
         op   = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         addr = $urandom;
         for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
         nw   = ($urandom_range(0, 1) == 0) ? 8 : $urandom_range(0, 12);
         run_txn(op, addr, model_ca(op, addr), wd, nw, 1'b0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4), 16'($urandom), $sformatf("rand%0d", t));
      end
   endtask

   task automatic test_reset_midflight();
      wait_ready("midreset");
      u_if.req_valid = 1'b1;
      u_if.req_op    = 2'd0;
      u_if.req_addr  = 32'h0000_0700;
      u_if.req_wdata = {8{32'h1357_9BDF}};
      @(negedge clk);
      u_if.req_valid = 1'b0;
      @(negedge clk);
      rdmem_wordvalid = 1'b1;
      rdmem_data      = 32'hDEAD_BEEF;
      @(negedge clk);
      rdmem_wordvalid = 1'b0;
      rst = 1'b0;
      #1;
      check_all_reset("midreset_wait_end");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (u_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset recover: got ready=%b want 1", u_if.req_ready);
      end
      u_if.req_valid = 1'b1;
      u_if.req_op    = 2'd1;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      @(negedge clk);
      wrmem_end = 1'b1;
      @(negedge clk);
      wrmem_end = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (u_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset resp_drop: got valid=%b busy=%b want 0 0", u_if.rsp_valid, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rdmem();
      test_wrmem();
      test_rdreg();
      test_short_burst();
      test_timeout();
      test_backpressure();
      test_illegal();
      test_stray_end();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
